cp0_irq_timer: RTL and testbench

//  Parametrised CP0 for the pipelined MIPS core: holds SR, Cause, EPC, Count, Compare and PRId.

---
 rtl/cp0_pkg.sv | 70 +++++++
 rtl/cp0_timer.sv | 73 +++++++
 rtl/cp0_irq_timer.sv | 174 +++++++++++++++++
 tb/tb_cp0_irq_timer.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/cp0_pkg.sv
// cp0_pkg
//   Shared definitions for the CP0 coprocessor slice of the pipelined MIPS core:
//   register addresses, exception codes and the bit positions of the SR and
//   Cause fields, plus helpers that assemble the architectural read views of
//   SR and Cause from their individual field registers.
package cp0_pkg;

  // CP0 register numbers used by mtc0/mfc0.
  localparam logic [4:0] CP0_COUNT   = 5'd9;
  localparam logic [4:0] CP0_COMPARE = 5'd11;
  localparam logic [4:0] CP0_SR      = 5'd12;
  localparam logic [4:0] CP0_CAUSE   = 5'd13;
  localparam logic [4:0] CP0_EPC     = 5'd14;
  localparam logic [4:0] CP0_PRID    = 5'd15;

  // Exception codes; EXC_INT doubles as "no synchronous exception".
  typedef enum logic [4:0] {
    EXC_INT  = 5'd0,
    EXC_ADEL = 5'd4,
    EXC_ADES = 5'd5,
    EXC_RI   = 5'd10,
    EXC_OV   = 5'd12
  } exc_code_e;

  // SR field positions.
  localparam int SR_IE_BIT  = 0;
  localparam int SR_EXL_BIT = 1;
  localparam int SR_IM_LSB  = 8;
  localparam int IM_W       = 8;

  // Cause field positions.
  localparam int CAUSE_EXC_LSB = 2;
  localparam int EXCCODE_W     = 5;
  localparam int CAUSE_IP_LSB  = 8;
  localparam int IP_W          = 8;
  localparam int CAUSE_DC_BIT  = 27;
  localparam int CAUSE_BD_BIT  = 31;

  // Hardware interrupt lines occupy IP/IM[15:10], software bits IP/IM[9:8].
  localparam int HWIP_LSB = 10;
  localparam int HWIP_W   = 6;
  localparam int SWIP_W   = 2;

  // Architectural SR view: only IM, EXL and IE exist, everything else reads 0.
  function automatic logic [31:0] pack_sr(input logic [IM_W-1:0] im,
                                          input logic exl,
                                          input logic ie);
    logic [31:0] v;
    v = '0;
    v[SR_IM_LSB +: IM_W] = im;
    v[SR_EXL_BIT]        = exl;
    v[SR_IE_BIT]         = ie;
    return v;
  endfunction

  // Architectural Cause view assembled from its field registers.
  function automatic logic [31:0] pack_cause(input logic bd,
                                             input logic dc,
                                             input logic [IP_W-1:0] ip,
                                             input logic [EXCCODE_W-1:0] exc);
    logic [31:0] v;
    v = '0;
    v[CAUSE_BD_BIT]                 = bd;
    v[CAUSE_DC_BIT]                 = dc;
    v[CAUSE_IP_LSB +: IP_W]         = ip;
    v[CAUSE_EXC_LSB +: EXCCODE_W]   = exc;
    return v;
  endfunction

endpackage

// File: rtl/cp0_timer.sv
// cp0_timer
//   Count/Compare timer of CP0. Count free-runs unless DC is set, Compare is a
//   plain register, and TI is a sticky flag raised when Count meets Compare and
//   dropped only by a write to Compare.
// Ports
//   clk         in  1        clock, rising edge
//   reset       in  1        synchronous, active-high
//   count_we    in  1        qualified mtc0 write to Count
//   compare_we  in  1        qualified mtc0 write to Compare
//   wdata       in  32       mtc0 write data
//   dc          in  1        Cause.DC, freezes Count when set
//   count       out COUNT_W  current Count register
//   compare     out COUNT_W  current Compare register
//   ti          out 1        timer interrupt flag
module cp0_timer #(
  parameter bit TIMER_EN = 1'b1,
  parameter int COUNT_W  = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               count_we,
  input  logic               compare_we,
  input  logic [31:0]        wdata,
  input  logic               dc,
  output logic [COUNT_W-1:0] count,
  output logic [COUNT_W-1:0] compare,
  output logic               ti
);

  generate
    if (TIMER_EN) begin : g_timer
      logic [COUNT_W-1:0] count_q;
      logic [COUNT_W-1:0] compare_q;
      logic               ti_q;
      logic [COUNT_W-1:0] wval;

      assign wval = wdata[COUNT_W-1:0];

      // A Compare write normally clears TI, but if the new value already
      // equals Count the match is reported on the very next cycle instead of
      // waiting for Count to come round again.
      always_ff @(posedge clk) begin
        if (reset) begin
          count_q   <= '0;
          compare_q <= '1;
          ti_q      <= 1'b0;
        end else begin
          if (count_we) begin
            count_q <= wval;
          end else if (!dc) begin
            count_q <= count_q + 1'b1;
          end

          if (compare_we) begin
            compare_q <= wval;
            ti_q      <= (wval == count_q);
          end else if (count_q == compare_q) begin
            ti_q <= 1'b1;
          end
        end
      end

      assign count   = count_q;
      assign compare = compare_q;
      assign ti      = ti_q;
    end else begin : g_no_timer
      assign count   = '0;
      assign compare = '0;
      assign ti      = 1'b0;
    end
  endgenerate

endmodule

// File: rtl/cp0_irq_timer.sv
// cp0_irq_timer
//   CP0 beside the M stage: SR, Cause, EPC, Count, Compare and PRId. Merges the
//   external interrupt lines, the two software interrupt bits and the timer
//   interrupt, and raises req in the same cycle so the pipeline can flush and
//   redirect to the handler.
// Ports
//   clk       in  1        clock, rising edge
//   reset     in  1        synchronous, active-high
//   en        in  1        mtc0 write strobe
//   cp0_addr  in  5        register select for read and write
//   cp0_in    in  32       mtc0 write data
//   vpc       in  32       PC of the M-stage instruction
//   bd_in     in  1        M-stage instruction sits in a branch delay slot
//   exc_code  in  5        synchronous exception code, EXC_INT = none
//   hw_int    in  N_HWINT  level-sensitive external interrupt lines
//   exl_clr   in  1        eret in M stage
//   cp0_out   out 32       combinational read data
//   epc_out   out 32       current EPC
//   req       out 1        combinational exception/interrupt request
module cp0_irq_timer
  import cp0_pkg::*;
#(
  parameter int          N_HWINT    = 6,
  parameter bit          TIMER_EN   = 1'b1,
  parameter int          TIMER_LINE = 5,
  parameter int          COUNT_W    = 32,
  parameter logic [31:0] PRID       = 32'h0000_0700
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               en,
  input  logic [4:0]         cp0_addr,
  input  logic [31:0]        cp0_in,
  input  logic [31:0]        vpc,
  input  logic               bd_in,
  input  logic [4:0]         exc_code,
  input  logic [N_HWINT-1:0] hw_int,
  input  logic               exl_clr,
  output logic [31:0]        cp0_out,
  output logic [31:0]        epc_out,
  output logic               req
);

  // SR fields
  logic [IM_W-1:0]      im;
  logic                 exl;
  logic                 ie;

  // Cause fields
  logic                 bd;
  logic                 dc;
  logic [HWIP_W-1:0]    ip_hw;
  logic [SWIP_W-1:0]    ip_sw;
  logic [EXCCODE_W-1:0] exc_q;

  logic [31:0]          epc;

  // Timer view
  logic [COUNT_W-1:0]   count;
  logic [COUNT_W-1:0]   compare;
  logic                 ti;

  logic [HWIP_W-1:0]    hw_pad;
  logic [IP_W-1:0]      ip_eff;
  logic                 int_pend;
  logic                 exc_pend;
  logic                 wr_ok;
  logic                 sr_we;
  logic                 cause_we;
  logic                 epc_we;
  logic                 count_we;
  logic                 compare_we;

  // Hardware lines padded to six bits, with the timer folded onto its line.
  always_comb begin
    hw_pad                = '0;
    hw_pad[N_HWINT-1:0]   = hw_int;
    hw_pad[TIMER_LINE]    = hw_pad[TIMER_LINE] | ti;
  end

  // The request uses the live pending bits, not the lagged Cause.IP copy,
  // so an interrupt is taken in the same cycle its line rises.
  assign ip_eff   = {hw_pad, ip_sw};
  assign int_pend = ie && |(ip_eff & im);
  assign exc_pend = (exc_code != EXC_INT);
  assign req      = !exl && (int_pend || exc_pend);

  // An exception or interrupt squashes any mtc0 issued in the same cycle.
  assign wr_ok      = en && !req;
  assign sr_we      = wr_ok && (cp0_addr == CP0_SR);
  assign cause_we   = wr_ok && (cp0_addr == CP0_CAUSE);
  assign epc_we     = wr_ok && (cp0_addr == CP0_EPC);
  assign count_we   = wr_ok && (cp0_addr == CP0_COUNT);
  assign compare_we = wr_ok && (cp0_addr == CP0_COMPARE);

  cp0_timer #(
    .TIMER_EN (TIMER_EN),
    .COUNT_W  (COUNT_W)
  ) u_timer (
    .clk        (clk),
    .reset      (reset),
    .count_we   (count_we),
    .compare_we (compare_we),
    .wdata      (cp0_in),
    .dc         (dc),
    .count      (count),
    .compare    (compare),
    .ti         (ti)
  );

  // SR, Cause and EPC. Cause.IP[15:10] is a one-cycle-late snapshot of the
  // hardware lines and is never software-writable. Exception entry takes
  // precedence over mtc0; an eret clearing EXL overrides the EXL bit of a
  // simultaneous SR write while IM and IE still take the written values.
  always_ff @(posedge clk) begin
    if (reset) begin
      im    <= '0;
      exl   <= 1'b0;
      ie    <= 1'b0;
      bd    <= 1'b0;
      dc    <= 1'b0;
      ip_hw <= '0;
      ip_sw <= '0;
      exc_q <= EXC_INT;
      epc   <= '0;
    end else begin
      ip_hw <= hw_pad;

      if (req) begin
        epc   <= bd_in ? (vpc - 32'd4) : vpc;
        bd    <= bd_in;
        exl   <= 1'b1;
        exc_q <= int_pend ? EXC_INT : exc_code;
      end else begin
        if (sr_we) begin
          im  <= cp0_in[SR_IM_LSB +: IM_W];
          exl <= cp0_in[SR_EXL_BIT];
          ie  <= cp0_in[SR_IE_BIT];
        end

        if (exl_clr && exl) begin
          exl <= 1'b0;
        end

        if (cause_we) begin
          dc    <= cp0_in[CAUSE_DC_BIT];
          ip_sw <= cp0_in[CAUSE_IP_LSB +: SWIP_W];
        end

        if (epc_we) begin
          epc <= cp0_in;
        end
      end
    end
  end

  // Read mux returns register contents only, so a same-cycle write is not
  // visible until the following cycle.
  always_comb begin
    cp0_out = '0;
    case (cp0_addr)
      CP0_COUNT:   cp0_out = 32'(count);
      CP0_COMPARE: cp0_out = 32'(compare);
      CP0_SR:      cp0_out = pack_sr(im, exl, ie);
      CP0_CAUSE:   cp0_out = pack_cause(bd, dc, {ip_hw, ip_sw}, exc_q);
      CP0_EPC:     cp0_out = epc;
      CP0_PRID:    cp0_out = PRID;
      default:     cp0_out = '0;
    endcase
  end

  assign epc_out = epc;

endmodule

// File: tb/tb_cp0_irq_timer.sv
// tb_cp0_irq_timer
//   Self-checking bench for cp0_irq_timer with default parameters. Each cycle
//   is described by one vector; its expected req/epc_out/cp0_out go into a
//   scoreboard queue when driven and are popped and compared mid-cycle.
module tb_cp0_irq_timer;
  import cp0_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        en;
  logic [4:0]  cp0_addr;
  logic [31:0] cp0_in;
  logic [31:0] vpc;
  logic        bd_in;
  logic [4:0]  exc_code;
  logic [5:0]  hw_int;
  logic        exl_clr;
  logic [31:0] cp0_out;
  logic [31:0] epc_out;
  logic        req;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        en;
    logic [4:0]  addr;
    logic [31:0] wdata;
    logic [31:0] vpc;
    logic        bd;
    logic [4:0]  exc;
    logic [5:0]  hw;
    logic        clr;
    logic        exp_req;
    logic        chk_out;
    logic [31:0] exp_out;
    logic [31:0] exp_epc;
  } vec_t;

  typedef struct {
    int          id;
    logic        exp_req;
    logic        chk_out;
    logic [31:0] exp_out;
    logic [31:0] exp_epc;
  } exp_t;

  exp_t sb[$];
  vec_t tbl[23];

  cp0_irq_timer dut (
    .clk      (clk),
    .reset    (reset),
    .en       (en),
    .cp0_addr (cp0_addr),
    .cp0_in   (cp0_in),
    .vpc      (vpc),
    .bd_in    (bd_in),
    .exc_code (exc_code),
    .hw_int   (hw_int),
    .exl_clr  (exl_clr),
    .cp0_out  (cp0_out),
    .epc_out  (epc_out),
    .req      (req)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(input logic en_v, input logic [4:0] addr,
                              input logic [31:0] wdata, input logic [31:0] pc,
                              input logic bd, input logic [4:0] exc,
                              input logic [5:0] hw, input logic clr,
                              input logic exp_req, input logic chk_out,
                              input logic [31:0] exp_out,
                              input logic [31:0] exp_epc);
    vec_t v;
    v.en = en_v; v.addr = addr; v.wdata = wdata; v.vpc = pc; v.bd = bd;
    v.exc = exc; v.hw = hw; v.clr = clr; v.exp_req = exp_req;
    v.chk_out = chk_out; v.exp_out = exp_out; v.exp_epc = exp_epc;
    return v;
  endfunction

  task automatic idleInputs();
    en = 1'b0; cp0_addr = '0; cp0_in = '0; vpc = '0; bd_in = 1'b0;
    exc_code = '0; hw_int = '0; exl_clr = 1'b0;
  endtask

  // Reset is held across two rising edges; returns 2 ns after the last one.
  task automatic doReset();
    idleInputs();
    reset = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #2;
    reset = 1'b0;
  endtask

  task automatic applyStimulus(input vec_t v, input int id);
    exp_t e;
    en = v.en; cp0_addr = v.addr; cp0_in = v.wdata; vpc = v.vpc;
    bd_in = v.bd; exc_code = v.exc; hw_int = v.hw; exl_clr = v.clr;
    e.id = id; e.exp_req = v.exp_req; e.chk_out = v.chk_out;
    e.exp_out = v.exp_out; e.exp_epc = v.exp_epc;
    sb.push_back(e);
  endtask

  task automatic checkOutput();
    exp_t e;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL scoreboard empty got 0 entries want 1");
      return;
    end
    e = sb.pop_front();
    checks++;
    if (req !== e.exp_req) begin
      errors++;
      $display("[TB] FAIL req id %0d got %b want %b", e.id, req, e.exp_req);
    end
    checks++;
    if (epc_out !== e.exp_epc) begin
      errors++;
      $display("[TB] FAIL epc_out id %0d got %h want %h", e.id, epc_out, e.exp_epc);
    end
    if (e.chk_out) begin
      checks++;
      if (cp0_out !== e.exp_out) begin
        errors++;
        $display("[TB] FAIL cp0_out id %0d addr %0d got %h want %h",
                 e.id, cp0_addr, cp0_out, e.exp_out);
      end
    end
  endtask

  // One cycle: drive at posedge+2, compare at posedge+4, advance.
  task automatic step(input vec_t v, input int id);
    applyStimulus(v, id);
    #2;
    checkOutput();
    @(posedge clk);
    #2;
  endtask

  initial begin
    // Hardware interrupts, synchronous exceptions, EXL masking, Cause write
    // mask, software interrupt with dropped mtc0, PRId and unmapped reads.
    tbl[0]  = mk(0, 12, 0, 0, 0, 0, 0, 0,              0, 1, 32'h0, 32'h0);
    tbl[1]  = mk(0, 13, 0, 0, 0, 0, 0, 0,              0, 1, 32'h0, 32'h0);
    tbl[2]  = mk(0, 11, 0, 0, 0, 0, 0, 0,              0, 1, 32'hFFFF_FFFF, 32'h0);
    tbl[3]  = mk(1, 12, 32'hFC01, 0, 0, 0, 0, 0,       0, 1, 32'h0, 32'h0);
    tbl[4]  = mk(0, 12, 0, 32'h3008, 0, 0, 6'b000100, 0, 1, 1, 32'hFC01, 32'h0);
    tbl[5]  = mk(0, 13, 0, 0, 0, 0, 6'b000100, 0,      0, 1, 32'h0000_1000, 32'h3008);
    tbl[6]  = mk(0, 12, 0, 0, 0, 0, 0, 0,              0, 1, 32'hFC03, 32'h3008);
    tbl[7]  = mk(1, 12, 32'hFC02, 0, 0, 0, 0, 1,       0, 1, 32'hFC03, 32'h3008);
    tbl[8]  = mk(0, 12, 0, 32'h3010, 1, EXC_OV, 0, 0,  1, 1, 32'hFC00, 32'h3008);
    tbl[9]  = mk(0, 13, 0, 0, 0, 0, 0, 0,              0, 1, 32'h8000_0030, 32'h300C);
    tbl[10] = mk(1, 12, 32'hFC03, 0, 0, 0, 0, 0,       0, 1, 32'hFC02, 32'h300C);
    tbl[11] = mk(0, 12, 0, 0, 0, EXC_RI, 6'b000001, 0, 0, 1, 32'hFC03, 32'h300C);
    tbl[12] = mk(0, 12, 0, 0, 0, EXC_RI, 6'b000001, 1, 0, 1, 32'hFC03, 32'h300C);
    tbl[13] = mk(0, 12, 0, 32'h4000, 0, EXC_RI, 6'b000001, 0, 1, 1, 32'hFC01, 32'h300C);
    tbl[14] = mk(0, 13, 0, 0, 0, 0, 0, 0,              0, 1, 32'h0000_0400, 32'h4000);
    tbl[15] = mk(1, 13, 32'hFFFF_FFFF, 0, 0, 0, 0, 0,  0, 1, 32'h0, 32'h4000);
    tbl[16] = mk(0, 13, 0, 0, 0, 0, 0, 0,              0, 1, 32'h0800_0300, 32'h4000);
    tbl[17] = mk(1, 12, 32'h0101, 0, 0, 0, 0, 1,       0, 1, 32'hFC03, 32'h4000);
    tbl[18] = mk(1, 14, 32'hDEAD_0000, 32'h5000, 0, 0, 0, 0, 1, 1, 32'h4000, 32'h4000);
    tbl[19] = mk(0, 14, 0, 0, 0, 0, 0, 0,              0, 1, 32'h5000, 32'h5000);
    tbl[20] = mk(0, 15, 0, 0, 0, 0, 0, 0,              0, 1, 32'h0000_0700, 32'h5000);
    tbl[21] = mk(0, 3, 0, 0, 0, 0, 0, 0,               0, 1, 32'h0, 32'h5000);
    tbl[22] = mk(0, 13, 0, 0, 0, 0, 0, 0,              0, 1, 32'h0800_0300, 32'h5000);

    $display("[TB] start");
    doReset();
    for (int i = 0; i < 23; i++) begin
      step(tbl[i], i);
    end

    // Timer: freeze Count, load Count=0 and Compare=5, enable line 5 via
    // IM[15], then release DC and watch TI raise req when Count reaches 6.
    doReset();
    step(mk(1, 13, 32'h0800_0000, 0, 0, 0, 0, 0, 0, 1, 32'h0, 32'h0), 100);
    step(mk(1, 9, 32'h0, 0, 0, 0, 0, 0,          0, 1, 32'h1, 32'h0), 101);
    step(mk(1, 11, 32'd5, 0, 0, 0, 0, 0,         0, 1, 32'hFFFF_FFFF, 32'h0), 102);
    step(mk(1, 12, 32'h8001, 0, 0, 0, 0, 0,      0, 1, 32'h0, 32'h0), 103);
    step(mk(1, 13, 32'h0, 0, 0, 0, 0, 0,         0, 1, 32'h0800_0000, 32'h0), 104);
    for (int k = 0; k <= 6; k++) begin
      step(mk(0, 9, 0, 32'h6000, 0, 0, 0, 0, (k == 6), 1, 32'(k), 32'h0), 110 + k);
    end
    step(mk(0, 13, 0, 0, 0, 0, 0, 0,             0, 1, 32'h0000_8000, 32'h6000), 120);
    step(mk(1, 11, 32'd100, 0, 0, 0, 0, 0,       0, 1, 32'd5, 32'h6000), 121);
    step(mk(0, 11, 0, 0, 0, 0, 0, 1,             0, 1, 32'd100, 32'h6000), 122);
    step(mk(0, 12, 0, 0, 0, 0, 0, 0,             0, 1, 32'h8001, 32'h6000), 123);
    step(mk(0, 13, 0, 0, 0, 0, 0, 0,             0, 1, 32'h0, 32'h6000), 124);

    // Compare written equal to a frozen Count: TI on the next cycle.
    step(mk(1, 13, 32'h0800_0000, 0, 0, 0, 0, 0, 0, 1, 32'h0, 32'h6000), 130);
    step(mk(1, 9, 32'h50, 0, 0, 0, 0, 0,         0, 0, 32'h0, 32'h6000), 131);
    step(mk(1, 11, 32'h50, 0, 0, 0, 0, 0,        0, 1, 32'd100, 32'h6000), 132);
    step(mk(0, 9, 0, 32'h7000, 0, 0, 0, 0,       1, 1, 32'h50, 32'h6000), 133);
    step(mk(0, 13, 0, 0, 0, 0, 0, 0,             0, 1, 32'h0800_8000, 32'h7000), 134);

    // Count wrap from all-ones, PRId, then reset with EXL=1 and TI set.
    step(mk(1, 9, 32'hFFFF_FFFF, 0, 0, 0, 0, 0,  0, 0, 32'h0, 32'h7000), 140);
    step(mk(1, 13, 32'h0, 0, 0, 0, 0, 0,         0, 1, 32'h0800_8000, 32'h7000), 141);
    step(mk(0, 9, 0, 0, 0, 0, 0, 0,              0, 1, 32'hFFFF_FFFF, 32'h7000), 142);
    step(mk(0, 9, 0, 0, 0, 0, 0, 0,              0, 1, 32'h0, 32'h7000), 143);
    step(mk(0, 15, 0, 0, 0, 0, 0, 0,             0, 1, 32'h0000_0700, 32'h7000), 144);
    doReset();
    step(mk(0, 9, 0, 0, 0, 0, 0, 0,              0, 1, 32'h0, 32'h0), 150);
    step(mk(0, 11, 0, 0, 0, 0, 0, 0,             0, 1, 32'hFFFF_FFFF, 32'h0), 151);
    step(mk(0, 12, 0, 0, 0, 0, 0, 0,             0, 1, 32'h0, 32'h0), 152);
    step(mk(0, 13, 0, 0, 0, 0, 0, 0,             0, 1, 32'h0, 32'h0), 153);
    step(mk(0, 14, 0, 0, 0, 0, 0, 0,             0, 1, 32'h0, 32'h0), 154);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
